// File: rtl/pipe_stage_buffer.sv
// Pipeline stage buffer with valid/ready handshake, flush-to-bubble and stall/flush counters.
// Define PIPE_STAGE_SKID_EN for a main+skid (registered ready) buffer; default is a single entry.
module pipe_stage_buffer #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              in_xfer, out_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              rdy_q;

    // Ready only looks at our own registered state, so out_ready_i never reaches it.
    assign in_ready_o = rdy_q;
`else
    assign in_ready_o = !reset_i && (!out_valid_o || out_ready_i);
`endif

    assign out_valid_o = (state_q != S_EMPTY);
    assign out_data_o  = main_data_q;
    assign out_ctrl_o  = main_ctrl_q;
    assign occupancy_o = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
`endif
        if (flush_i) begin
            // Bubble: control zeroed, data left as is.
            state_d     = S_EMPTY;
            main_ctrl_d = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_xfer) begin
                        main_data_d = in_data_i;
                        main_ctrl_d = in_ctrl_i;
                        state_d     = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data_i;
                        main_ctrl_d = in_ctrl_i;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_xfer) begin
                        skid_data_d = in_data_i;
                        skid_ctrl_d = in_ctrl_i;
                        state_d     = S_FULL;
`endif
                    end else if (out_xfer) begin
                        state_d = S_EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                S_FULL: begin
                    if (out_xfer) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = S_ONE;
                    end
                end
`endif
                default: state_d = S_EMPTY;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && !out_ready_i && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        flush_cnt_d = flush_cnt_q;
        if (flush_i && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            rdy_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            rdy_q       <= (state_d != S_FULL);
`endif
        end
    end
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: vector table plus stream, flush, saturation and async-reset sequences.
module tb_pipe_stage_buffer;
    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [15:0] in_ctrl, out_ctrl, stall_cnt, flush_cnt;
    logic [1:0]  occ;
    logic        ir4, ov4;
    logic [31:0] d4;
    logic [15:0] c4;
    logic [1:0]  occ4;
    logic [3:0]  st4, fc4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer u_dut (
        .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_ctrl_o(out_ctrl),
        .occupancy_o(occ), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipe_stage_buffer #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid), .in_ready_o(ir4),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .flush_i(flush), .out_valid_o(ov4),
        .out_ready_i(out_ready), .out_data_o(d4), .out_ctrl_o(c4),
        .occupancy_o(occ4), .stall_cnt_o(st4), .flush_cnt_o(fc4)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [15:0] c;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_d;
        logic [15:0] e_c;
        logic [1:0]  e_occ;
        logic        chk_ir;
        logic        e_ir;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_i   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int sent, got;
        in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;

        //           v   d             c         or  fl  ov  e_d           e_c       occ  chk ir
        tbl[0] = '{1'b1, 32'h0000_1000, 16'h00A5, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 16'h00A5, 2'd1, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 32'h0000_2222, 16'h0011, 1'b1, 1'b0, 1'b1, 32'h0000_2222, 16'h0011, 2'd1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 32'hDEAD_DEAD, 16'hFFFF, 1'b0, 1'b0, 1'b1, 32'h0000_2222, 16'h0011, 2'd1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 32'hBEEF_BEEF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'h0000_2222, 16'h0011, 2'd0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 32'h1234_5678, 16'h5A5A, 1'b1, 1'b0, 1'b0, 32'h0000_2222, 16'h0011, 2'd0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 32'h0000_3333, 16'h0033, 1'b0, 1'b0, 1'b1, 32'h0000_3333, 16'h0033, 2'd1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0000_3333, 16'h0000, 2'd0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 32'h0000_4444, 16'h0044, 1'b1, 1'b1, 1'b0, 32'h0000_3333, 16'h0000, 2'd0, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 32'h0000_5555, 16'h0055, 1'b1, 1'b0, 1'b1, 32'h0000_5555, 16'h0055, 2'd1, 1'b1, 1'b1};

        // Reset is observed before any clock edge.
        #1 reset_i = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_occ", 64'(occ), 64'd0);
        chk("rst_cnts", 64'({stall_cnt, flush_cnt}), 64'd0);
        do_reset();
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; in_ctrl = tbl[i].c;
            out_ready = tbl[i].ordy; flush = tbl[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(tbl[i].e_d));
            chk($sformatf("vec%0d_out_ctrl", i), 64'(out_ctrl), 64'(tbl[i].e_c));
            chk($sformatf("vec%0d_occ", i), 64'(occ), 64'(tbl[i].e_occ));
            if (tbl[i].chk_ir)
                chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
        end
        flush = 1'b0;
        chk("tbl_stall_cnt", 64'(stall_cnt), 64'd2);
        chk("tbl_flush_cnt", 64'(flush_cnt), 64'd2);

        // Simultaneous in/out while holding one entry.
        in_valid = 1'b1; in_data = 32'h0000_6666; in_ctrl = 16'h0066; out_ready = 1'b1;
        #1;
        chk("passthru_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("passthru_occ", 64'(occ), 64'd1);
        chk("passthru_data", 64'(out_data), 64'h6666);
        chk("passthru_ctrl", 64'(out_ctrl), 64'h0066);

        // Stream 1..8 with downstream stalled in cycles 3-5.
        do_reset();
        sent = 0; got = 0;
        for (int cyc = 1; cyc <= 40 && got < 8; cyc++) begin
            in_valid  = (sent < 8);
            in_data   = 32'(sent + 1);
            in_ctrl   = 16'(sent + 1);
            out_ready = !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("stream_order", 64'(out_data), 64'(got + 1));
                got++;
            end
`ifdef PIPE_STAGE_SKID_EN
            if (occ == 2'd2) chk("stream_full_not_ready", 64'(in_ready), 64'd0);
`else
            chk("stream_occ_max", 64'(occ <= 2'd1), 64'd1);
`endif
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 64'(got), 64'd8);
        chk("stream_stall_cnt", 64'(stall_cnt), 64'd3);

        // Flush with held payloads and an input presented in the same cycle.
        do_reset();
        in_valid = 1'b1; in_data = 32'h0A; in_ctrl = 16'h0A; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 32'h0B; in_ctrl = 16'h0B;
        @(posedge clk); #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("flush_pre_occ", 64'(occ), 64'd2);
`else
        chk("flush_pre_occ", 64'(occ), 64'd1);
`endif
        flush = 1'b1; in_data = 32'h0C; in_ctrl = 16'h0C;
        @(posedge clk); #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("flush_occ", 64'(occ), 64'd0);
        chk("flush_cnt", 64'(flush_cnt), 64'd1);
        chk("flush_data_kept", 64'(out_data), 64'h0A);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("flush_no_ghost", 64'(out_valid), 64'd0);
        end

        // Stall counter saturation (CNT_W=4 instance alongside the default one).
        do_reset();
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 16'h77; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("stall_sat_cnt4", 64'(st4), 64'hF);
        chk("stall_cnt_20", 64'(stall_cnt), 64'd20);

        // Asynchronous reset mid-cycle with payloads held.
        in_valid = 1'b1; in_data = 32'h88; in_ctrl = 16'h88;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk("areset_out_valid", 64'(out_valid), 64'd0);
        chk("areset_in_ready", 64'(in_ready), 64'd0);
        chk("areset_data_ctrl", 64'({out_data, out_ctrl}), 64'd0);
        chk("areset_occ", 64'(occ), 64'd0);
        chk("areset_cnts", 64'({stall_cnt, flush_cnt, st4, fc4}), 64'd0);
        #1 reset_i = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        #1;
        chk("release_ready_low", 64'(in_ready), 64'd0);
`endif
        @(posedge clk); #1;
        chk("release_ready_high", 64'(in_ready), 64'd1);
        chk("release_occ", 64'(occ), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 Parameter DATA_W, default 32, width of datapath payload (PC, operands, offset).
REQ-002 Parameter CTRL_W, default 16, width of control payload (alu op, mem/reg-write enables, branch/jump bits).
REQ-003 Parameter CNT_W, default 16, width of each performance counter.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  reset, asynchronous, active-high.
REQ-006 in_valid_i  input  1  upstream stage presents a valid payload.
REQ-007 in_ready_o  output  1  this stage accepts the payload this cycle.
REQ-008 in_data_i  input  DATA_W  upstream data payload.
REQ-009 in_ctrl_i  input  CTRL_W  upstream control payload.
REQ-010 flush_i  input  1  squash all held and incoming payloads (branch mispredict, exception).
REQ-011 out_valid_o  output  1  held payload valid toward downstream stage.
REQ-012 out_ready_i  input  1  downstream accepts the payload this cycle.
REQ-013 out_data_o  output  DATA_W  held data payload.
REQ-014 out_ctrl_o  output  CTRL_W  held control payload.
REQ-015 occupancy_o  output  2  number of valid entries held (0..2).
REQ-016 stall_cnt_o  output  CNT_W  cycles with out_valid_o=1 and out_ready_i=0.
REQ-017 flush_cnt_o  output  CNT_W  cycles with flush_i=1.

Function
REQ-018 Transfer in occurs on a rising edge when in_valid_i=1 and in_ready_o=1; transfer out occurs when out_valid_o=1 and out_ready_i=1.
REQ-019 Payloads leave in acceptance order; no payload is duplicated or dropped except by flush.
REQ-020 Latency SHALL be one cycle: payload accepted at edge N is on out_*_o after edge N when the stage was empty.
REQ-021 Storage SHALL be a main entry (drives out_*_o) plus a skid entry; state = EMPTY (0), ONE (main valid), FULL (main+skid valid).
REQ-022 EMPTY->ONE on transfer in; ONE->ONE on simultaneous in/out; ONE->FULL on transfer in without transfer out; ONE->EMPTY on transfer out only; FULL->ONE on transfer out (skid moves to main, no transfer in possible).
REQ-023 in_ready_o SHALL be a registered signal equal to NOT(skid valid); no combinational path from out_ready_i to in_ready_o.
REQ-024 out_data_o/out_ctrl_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-025 flush_i=1 at edge N SHALL clear both entries (state EMPTY), force out_ctrl_o to 0 (bubble), keep out_data_o unchanged, and discard any input presented in that cycle; flush overrides simultaneous transfers.
REQ-026 occupancy_o SHALL equal the number of valid entries after each edge.
REQ-027 stall_cnt_o SHALL increment by 1 per qualifying cycle and saturate at 2^CNT_W-1.
REQ-028 flush_cnt_o SHALL increment by 1 per cycle with flush_i=1 and saturate at 2^CNT_W-1.
REQ-029 Input data/ctrl values while in_valid_i=0 SHALL have no effect on state.

Reset
REQ-030 While reset_i=1, independent of clk_i: out_valid_o=0, in_ready_o=0, out_data_o=0, out_ctrl_o=0, occupancy_o=0, stall_cnt_o=0, flush_cnt_o=0, skid entry cleared.
REQ-031 First rising edge after reset_i deasserts SHALL set in_ready_o=1; reset asserted mid-transfer SHALL discard all payloads.

Configuration
REQ-032 Macro PIPE_STAGE_SKID_EN selects storage depth.
REQ-033 With PIPE_STAGE_SKID_EN defined: two-entry behaviour of REQ-021..REQ-023.
REQ-034 Without it: main entry only; in_ready_o = NOT out_valid_o OR out_ready_i (combinational, forced 0 during reset); occupancy_o never exceeds 1; all other requirements unchanged.

Verification
REQ-035 Reset, then in_valid_i=1, in_data_i=32'h0000_1000, in_ctrl_i=16'h00A5, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=32'h0000_1000, out_ctrl_o=16'h00A5, occupancy_o=1.
REQ-036 Stream 8 payloads 1..8 with out_ready_i=0 for cycles 3-5 -> outputs 1..8 in order, in_ready_o=0 while occupancy_o=2, stall_cnt_o=3.
REQ-037 FULL state, flush_i=1 one cycle with in_valid_i=1 -> next cycle out_valid_o=0, out_ctrl_o=0, occupancy_o=0, flush_cnt_o=1, flushed input never appears.
REQ-038 CNT_W=4, out_valid_o=1, out_ready_i=0 for 20 cycles -> stall_cnt_o stops at 4'hF.
REQ-039 reset_i asserted asynchronously mid-cycle in FULL state -> all outputs 0 before next clock edge; in_ready_o=1 one edge after release.
REQ-040 Build without PIPE_STAGE_SKID_EN, out_valid_o=1, out_ready_i=1, in_valid_i=1 -> in_ready_o=1 same cycle, occupancy_o stays 1.
